// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   state_t       transmitter FSM states
//   DATA_BITS     payload bits per frame
//   clks_per_bit  system-clock cycles per serial bit
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Integer divide; any remainder shows up as a small baud-rate error.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO feeding the UART transmitter.
// Ports:
//   clk      in   system clock
//   rst_n    in   async active-low reset (clears pointers/count, not storage)
//   wr_en    in   push strobe, ignored while full
//   wr_data  in   byte to push
//   rd_en    in   pop strobe, ignored while empty
//   rd_data  out  combinational head entry
//   full     out  DEPTH entries held
//   empty    out  no entries held
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  // full is taken from the registered count, so a pop on the same edge
  // never opens a slot for a push.
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 RS-232 transmitter with an internal baud divider.
// Ports:
//   clk       in   system clock
//   rst_n     in   async active-low reset; aborts any frame, line goes high
//   wr_data   in   byte to queue
//   wr_en     in   push strobe, one byte per high cycle
//   full      out  FIFO holds DEPTH entries
//   overflow  out  one-cycle pulse after a push was dropped because full
//   tx        out  registered serial line, idle high
//   busy      out  frame in progress (start through stop)
//   tx_done   out  one-cycle pulse on the final cycle of each stop bit
//
// state | meaning
// IDLE  | line high, waiting for FIFO data
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); chains straight into START if FIFO has data
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       full,
  output logic       overflow,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CPB - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       baud_cnt, baud_nxt;
  logic [IDX_W-1:0]       bit_idx, bit_nxt;
  logic [DATA_BITS-1:0]   shift, shift_nxt;
  logic                   tx_r, tx_nxt;
  logic                   overflow_r;
  logic                   tx_done_r;
  logic                   pop;
  logic                   empty;
  logic [DATA_BITS-1:0]   head;
  logic                   bit_end;

  uart_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign bit_end  = (baud_cnt == CNT_LAST);
  assign tx       = tx_r;
  assign busy     = (state != IDLE);
  assign overflow = overflow_r;
  assign tx_done  = tx_done_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_r     <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shift    <= shift_nxt;
      tx_r     <= tx_nxt;
    end
  end

  // tx is registered from the next-state value, so the line changes on the
  // same edge as the state and never glitches.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    tx_nxt    = tx_r;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = head;
          bit_nxt   = '0;
          baud_nxt  = '0;
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = DATA;
          tx_nxt    = shift[0];
        end else begin
          baud_nxt = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift[DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt = bit_idx + IDX_W'(1);
            tx_nxt  = shift[1];
          end
        end else begin
          baud_nxt = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = head;
            bit_nxt   = '0;
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  // tx_done is armed one cycle early so the registered pulse lands on the
  // last cycle of the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      overflow_r <= wr_en && full;
      tx_done_r  <= (state == STOP) && (baud_cnt == CNT_PRE);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       overflow;
  logic       tx;
  logic       busy;
  logic       tx_done;

  uart_tx_fifo #(
    .CLK_FREQ(16),
    .BAUD    (1),
    .DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .overflow (overflow),
    .tx       (tx),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Frame-level reference: queue of waiting bytes plus cycles left in the
  // frame currently on the line.
  logic [7:0] mq[$];
  logic [7:0] done_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] cur;
  int         rem;
  logic       m_ovf;
  int         done_total = 0;
  int         rx_total   = 0;
  int         frame_err  = 0;
  int         n_pulse    = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [4:0] exp_vec();
    logic ex_tx;
    int   pos;
    if (rem == 0) begin
      ex_tx = 1'b1;
    end else begin
      pos = (FRAME - rem) / CPB;
      if (pos == 0)      ex_tx = 1'b0;
      else if (pos == 9) ex_tx = 1'b1;
      else               ex_tx = cur[pos-1];
    end
    return {ex_tx, rem != 0, rem == 1, mq.size() == DEPTH, m_ovf};
  endfunction

  task automatic step(input logic we, input logic [7:0] d);
    logic full_m;
    wr_en   = we;
    wr_data = d;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      rem   = 0;
      m_ovf = 1'b0;
    end else begin
      full_m = (mq.size() == DEPTH);
      m_ovf  = we && full_m;
      if (rem <= 1) begin
        if (rem == 1) begin
          done_q.push_back(cur);
          done_total++;
        end
        if (mq.size() > 0) begin
          cur = mq.pop_front();
          rem = FRAME;
        end else begin
          rem = 0;
        end
      end else begin
        rem--;
      end
      if (we && !full_m) mq.push_back(d);
    end
    #1;
    wr_en = 1'b0;
    if (tx_done) n_pulse++;
    check_val("cycle", {27'd0, tx, busy, tx_done, full, overflow}, {27'd0, exp_vec()});
  endtask

  task automatic drain_check(input string tag);
    while (rx_q.size() > 0 && done_q.size() > 0)
      check_val(tag, rx_q.pop_front(), done_q.pop_front());
    check_val({tag, "_count"}, rx_q.size(), done_q.size());
    rx_q.delete();
    done_q.delete();
  endtask

  // Line decoder: samples each bit at its centre on the falling clock edge.
  int         mon_cnt = 0;
  bit         mon_act = 1'b0;
  logic [7:0] mon_byte;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (tx === 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CPB == CPB / 2) begin
        if (mon_cnt / CPB >= 1 && mon_cnt / CPB <= 8) begin
          mon_byte[mon_cnt / CPB - 1] = tx;
        end else if (mon_cnt / CPB == 9) begin
          if (tx !== 1'b1) frame_err++;
          rx_q.push_back(mon_byte);
          rx_total++;
          mon_act = 1'b0;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int p0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rem     = 0;
    m_ovf   = 1'b0;
    cur     = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_val("reset_state", {27'd0, tx, busy, tx_done, full, overflow}, 32'b10000);

    // idle after reset
    p0 = n_pulse;
    repeat (50) step(1'b0, 8'h00);
    check_val("idle_pulses", n_pulse - p0, 0);

    // single byte
    p0 = n_pulse;
    step(1'b1, 8'hA5);
    check_val("a5_tx_e0", tx, 1);
    step(1'b0, 8'h00);
    check_val("a5_tx_e1", tx, 0);
    repeat (170) step(1'b0, 8'h00);
    check_val("a5_pulses", n_pulse - p0, 1);
    drain_check("a5_byte");

    // three back-to-back frames
    p0 = n_pulse;
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h55);
    repeat (490) step(1'b0, 8'h00);
    check_val("b2b_pulses", n_pulse - p0, 3);
    drain_check("b2b_byte");

    // five pushes while idle fill the FIFO
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
    check_val("fill_full", full, 1);
    repeat (5 * FRAME + 20) step(1'b0, 8'h00);
    drain_check("fill_byte");

    // six pushes with the line stalled mid-frame
    step(1'b1, 8'($urandom));
    repeat (30) step(1'b0, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom));
    check_val("stall_ovf", overflow, 1);
    repeat (6 * FRAME + 20) step(1'b0, 8'h00);
    drain_check("stall_byte");

    // push landing on the last stop cycle
    step(1'b1, 8'($urandom));
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (rem == 1) found = 1'b1;
      else step(1'b0, 8'h00);
    end
    check_val("edge_reach", found, 1);
    step(1'b1, 8'($urandom));
    check_val("edge_gap_busy", busy, 0);
    step(1'b0, 8'h00);
    check_val("edge_start", tx, 0);
    repeat (FRAME + 20) step(1'b0, 8'h00);
    drain_check("edge_byte");

    // randomized bursts
    for (int b = 0; b < 50; b++) begin
      int len;
      int gap;
      len = $urandom_range(1, 6);
      gap = $urandom_range(0, 200);
      for (int i = 0; i < len; i++) step(1'b1, 8'($urandom));
      for (int i = 0; i < gap; i++) step(($urandom_range(0, 15) == 0), 8'($urandom));
    end
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (rem == 0 && mq.size() == 0) found = 1'b1;
      else step(1'b0, 8'h00);
    end
    check_val("rand_drained", found, 1);
    repeat (5) step(1'b0, 8'h00);
    drain_check("rand_byte");

    // async reset mid-DATA aborts the frame
    step(1'b1, 8'h3C);
    repeat (4 * CPB) step(1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_tx", tx, 1);
    check_val("abort_busy", busy, 0);
    mq.delete();
    rem   = 0;
    m_ovf = 1'b0;
    repeat (3) step(1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (40) step(1'b0, 8'h00);
    check_val("post_reset_tx", tx, 1);
    drain_check("post_reset");

    check_val("stop_bits", frame_err, 0);
    check_val("total_bytes", rx_total, done_total);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
